// File: rtl/video_pattern_gen.sv
// Parametrised video timing and test-pattern generator for the clk_pixel domain, feeding vga2dvid.
// Optional build macro VIDEO_PATTERN_BORDER_EN adds a 1-pixel white border around the active area.
module video_pattern_gen #(
  parameter int C_resolution_x      = 1280,
  parameter int C_hsync_front_porch = 82,
  parameter int C_hsync_pulse       = 80,
  parameter int C_hsync_back_porch  = 216,
  parameter int C_resolution_y      = 720,
  parameter int C_vsync_front_porch = 3,
  parameter int C_vsync_pulse       = 5,
  parameter int C_vsync_back_porch  = 22,
  parameter bit C_hsync_pol         = 1'b1,
  parameter bit C_vsync_pol         = 1'b1,
  parameter int C_check_log2        = 5,
  parameter int C_cnt_bits          = 12
) (
  input  logic                  clk_pixel,
  input  logic                  rst_n,
  input  logic [2:0]            mode,
  input  logic [23:0]           solid_rgb,
  output logic [7:0]            vga_r,
  output logic [7:0]            vga_g,
  output logic [7:0]            vga_b,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic                  vga_blank,
  output logic [C_cnt_bits-1:0] pos_x,
  output logic [C_cnt_bits-1:0] pos_y,
  output logic [15:0]           frame_cnt
);

  localparam int H_TOTAL = C_resolution_x + C_hsync_front_porch + C_hsync_pulse + C_hsync_back_porch;
  localparam int V_TOTAL = C_resolution_y + C_vsync_front_porch + C_vsync_pulse + C_vsync_back_porch;

  localparam logic [C_cnt_bits-1:0] H_ACT    = C_cnt_bits'(C_resolution_x);
  localparam logic [C_cnt_bits-1:0] H_SYNC_S = C_cnt_bits'(C_resolution_x + C_hsync_front_porch);
  localparam logic [C_cnt_bits-1:0] H_SYNC_E = C_cnt_bits'(C_resolution_x + C_hsync_front_porch + C_hsync_pulse);
  localparam logic [C_cnt_bits-1:0] H_LAST   = C_cnt_bits'(H_TOTAL - 1);
  localparam logic [C_cnt_bits-1:0] V_ACT    = C_cnt_bits'(C_resolution_y);
  localparam logic [C_cnt_bits-1:0] V_SYNC_S = C_cnt_bits'(C_resolution_y + C_vsync_front_porch);
  localparam logic [C_cnt_bits-1:0] V_SYNC_E = C_cnt_bits'(C_resolution_y + C_vsync_front_porch + C_vsync_pulse);
  localparam logic [C_cnt_bits-1:0] V_LAST   = C_cnt_bits'(V_TOTAL - 1);
  localparam logic [C_cnt_bits-1:0] BAR_W    = C_cnt_bits'(C_resolution_x / 8);
  localparam logic [C_cnt_bits-1:0] MBAR_W   = C_cnt_bits'(16);

  logic [C_cnt_bits-1:0] hcnt_q, hcnt_d;
  logic [C_cnt_bits-1:0] vcnt_q, vcnt_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [2:0]            mode_q, mode_d;
  logic [23:0]           rgb_q, rgb_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic                  blank_q, blank_d;
  logic [C_cnt_bits-1:0] pos_x_q, pos_y_q;

  logic                  line_end, frame_end, frame_start, active;
  logic [2:0]            bar_sel;
  logic [C_cnt_bits-1:0] mbar_off;
  logic [23:0]           pat_rgb;

  always_comb begin
    line_end    = (hcnt_q == H_LAST);
    frame_end   = line_end && (vcnt_q == V_LAST);
    frame_start = (hcnt_q == '0) && (vcnt_q == '0);
    active      = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);

    hcnt_d      = line_end ? '0 : hcnt_q + 1'b1;
    vcnt_d      = vcnt_q;
    if (line_end) vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    frame_cnt_d = frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;
    // The frame's first pixel already uses the freshly sampled mode.
    mode_d      = frame_start ? mode : mode_q;
  end

  always_comb begin
    bar_sel  = 3'(hcnt_q / BAR_W);
    mbar_off = hcnt_q - C_cnt_bits'(frame_cnt_q);
    pat_rgb  = 24'h000000;
    case (mode_d)
      3'd0: pat_rgb = {{8{~bar_sel[1]}}, {8{~bar_sel[2]}}, {8{~bar_sel[0]}}};
      3'd1: pat_rgb = {24{hcnt_q[C_check_log2] ^ vcnt_q[C_check_log2]}};
      3'd2: pat_rgb = {8'(hcnt_q), 8'(vcnt_q), frame_cnt_q[7:0]};
      3'd3: pat_rgb = solid_rgb;
      3'd4: pat_rgb = {24{mbar_off < MBAR_W}};
      default: pat_rgb = 24'h000000;
    endcase
`ifdef VIDEO_PATTERN_BORDER_EN
    if (hcnt_q == '0 || hcnt_q == H_ACT - 1'b1 || vcnt_q == '0 || vcnt_q == V_ACT - 1'b1)
      pat_rgb = 24'hFFFFFF;
`endif
  end

  always_comb begin
    rgb_d   = active ? pat_rgb : 24'h000000;
    blank_d = ~active;
    hsync_d = ((hcnt_q >= H_SYNC_S) && (hcnt_q < H_SYNC_E)) ? C_hsync_pol : ~C_hsync_pol;
    vsync_d = ((vcnt_q >= V_SYNC_S) && (vcnt_q < V_SYNC_E)) ? C_vsync_pol : ~C_vsync_pol;
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      frame_cnt_q <= 16'd0;
      mode_q      <= 3'd0;
      rgb_q       <= 24'h000000;
      blank_q     <= 1'b1;
      hsync_q     <= ~C_hsync_pol;
      vsync_q     <= ~C_vsync_pol;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      frame_cnt_q <= frame_cnt_d;
      mode_q      <= mode_d;
      rgb_q       <= rgb_d;
      blank_q     <= blank_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      pos_x_q     <= hcnt_q;
      pos_y_q     <= vcnt_q;
    end
  end

  assign vga_r     = rgb_q[23:16];
  assign vga_g     = rgb_q[15:8];
  assign vga_b     = rgb_q[7:0];
  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;
  assign vga_blank = blank_q;
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen on a 16x8 raster (htotal 25, vtotal 14), with a second
// instance at inverted sync polarity sharing clock, reset and pattern inputs.
module tb_video_pattern_gen;
  localparam int CW = 12;
  localparam int W  = 67;
  localparam int HT = 25;
  localparam int VT = 14;
`ifdef VIDEO_PATTERN_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    mode;
  logic [23:0]   solid;
  logic [7:0]    r, g, b, r0, g0, b0;
  logic          hs, vs, blank, hs0, vs0, blank0;
  logic [CW-1:0] px, py, px0, py0;
  logic [15:0]   fc, fc0;

  video_pattern_gen #(
    .C_resolution_x(16), .C_hsync_front_porch(2), .C_hsync_pulse(3), .C_hsync_back_porch(4),
    .C_resolution_y(8), .C_vsync_front_porch(1), .C_vsync_pulse(2), .C_vsync_back_porch(3),
    .C_hsync_pol(1'b1), .C_vsync_pol(1'b1), .C_check_log2(2), .C_cnt_bits(CW)
  ) dut (
    .clk_pixel(clk), .rst_n(rst_n), .mode(mode), .solid_rgb(solid),
    .vga_r(r), .vga_g(g), .vga_b(b), .vga_hsync(hs), .vga_vsync(vs), .vga_blank(blank),
    .pos_x(px), .pos_y(py), .frame_cnt(fc)
  );

  video_pattern_gen #(
    .C_resolution_x(16), .C_hsync_front_porch(2), .C_hsync_pulse(3), .C_hsync_back_porch(4),
    .C_resolution_y(8), .C_vsync_front_porch(1), .C_vsync_pulse(2), .C_vsync_back_porch(3),
    .C_hsync_pol(1'b0), .C_vsync_pol(1'b0), .C_check_log2(2), .C_cnt_bits(CW)
  ) dut_p0 (
    .clk_pixel(clk), .rst_n(rst_n), .mode(mode), .solid_rgb(solid),
    .vga_r(r0), .vga_g(g0), .vga_b(b0), .vga_hsync(hs0), .vga_vsync(vs0), .vga_blank(blank0),
    .pos_x(px0), .pos_y(py0), .frame_cnt(fc0)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [23:0] rgb;
    logic        hs, vs, blank;
    int          fc;
  } vec_t;

  vec_t           tbl[$];
  logic [W-1:0]   exp_q[$];
  int             checks = 0;
  int             failures = 0;

  function automatic void add(int cyc, logic [23:0] rgb, logic h, logic v, logic bl, int f);
    tbl.push_back('{cyc, rgb, h, v, bl, f});
  endfunction

  // Expected packed output word; the border build turns edge pixels white.
  function automatic logic [W-1:0] exp_word(logic [23:0] rgb, logic h, logic v, logic bl,
                                            int x, int y, int f);
    logic [23:0] c;
    c = rgb;
    if (BORDER && !bl && (x == 0 || x == 15 || y == 0 || y == 7)) c = 24'hFFFFFF;
    return {c, h, v, bl, CW'(x), CW'(y), 16'(f)};
  endfunction

  function automatic logic [W-1:0] act_word();
    return {r, g, b, hs, vs, blank, px, py, fc};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, e);
    end
  endtask

  initial begin
    // Bars (bar width 2), sync windows, blanking, frame boundary
    add(0,    24'hFFFFFF, 0, 0, 0, 0);  add(1,    24'hFFFFFF, 0, 0, 0, 0);
    add(2,    24'hFFFF00, 0, 0, 0, 0);  add(3,    24'hFFFF00, 0, 0, 0, 0);
    add(5,    24'h00FFFF, 0, 0, 0, 0);  add(7,    24'h00FF00, 0, 0, 0, 0);
    add(9,    24'hFF00FF, 0, 0, 0, 0);  add(11,   24'hFF0000, 0, 0, 0, 0);
    add(13,   24'h0000FF, 0, 0, 0, 0);  add(15,   24'h000000, 0, 0, 0, 0);
    add(16,   24'h000000, 0, 0, 1, 0);  add(17,   24'h000000, 0, 0, 1, 0);
    add(18,   24'h000000, 1, 0, 1, 0);  add(20,   24'h000000, 1, 0, 1, 0);
    add(21,   24'h000000, 0, 0, 1, 0);  add(110,  24'hFF0000, 0, 0, 0, 0);
    add(137,  24'h0000FF, 0, 0, 0, 0);  add(200,  24'h000000, 0, 0, 1, 0);
    add(224,  24'h000000, 0, 0, 1, 0);  add(225,  24'h000000, 0, 1, 1, 0);
    add(243,  24'h000000, 1, 1, 1, 0);  add(274,  24'h000000, 0, 1, 1, 0);
    add(275,  24'h000000, 0, 0, 1, 0);  add(348,  24'h000000, 0, 0, 1, 0);
    add(349,  24'h000000, 0, 0, 1, 1);
    // Solid 123456 from frame 1 on
    add(350,  24'h123456, 0, 0, 0, 1);  add(366,  24'h000000, 0, 0, 1, 1);
    add(440,  24'h123456, 0, 0, 0, 1);  add(700,  24'h123456, 0, 0, 0, 2);
    // Checkerboard, 4-pixel squares
    add(1050, 24'h000000, 0, 0, 0, 3);  add(1054, 24'hFFFFFF, 0, 0, 0, 3);
    add(1058, 24'h000000, 0, 0, 0, 3);  add(1150, 24'hFFFFFF, 0, 0, 0, 3);
    add(1154, 24'h000000, 0, 0, 0, 3);
    // Gradient with frame_cnt 4
    add(1528, 24'h030504, 0, 0, 0, 4);  add(1590, 24'h0F0704, 0, 0, 0, 4);
    // Moving bar with frame_cnt 5: white for x >= 5
    add(1750, 24'h000000, 0, 0, 0, 5);  add(1804, 24'h000000, 0, 0, 0, 5);
    add(1805, 24'hFFFFFF, 0, 0, 0, 5);
    // Modes 5..7 black
    add(2100, 24'h000000, 0, 0, 0, 6);  add(2182, 24'h000000, 0, 0, 0, 6);
    add(2190, 24'h000000, 0, 0, 0, 6);
    add(2505, 24'hABCDEF, 0, 0, 0, 7);
  end

  initial begin
    int idx;
    rst_n = 1'b0;
    mode  = 3'd0;
    solid = 24'h000000;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(exp_word(24'h0, 0, 0, 1, 0, 0, 0));
    check("reset_state", act_word());
    exp_q.push_back(W'(2'b11));
    check("reset_pol0_sync", W'({hs0, vs0}));

    @(negedge clk);
    rst_n = 1'b1;
    idx = 0;
    for (int k = 0; k <= 2505; k++) begin
      @(posedge clk);
      #1;
      if (idx < tbl.size() && tbl[idx].cyc == k) begin
        exp_q.push_back(exp_word(tbl[idx].rgb, tbl[idx].hs, tbl[idx].vs, tbl[idx].blank,
                                 k % HT, (k / HT) % VT, tbl[idx].fc));
        check($sformatf("vec@%0d", k), act_word());
        exp_q.push_back(W'({~tbl[idx].hs, ~tbl[idx].vs}));
        check($sformatf("pol0_sync@%0d", k), W'({hs0, vs0}));
        idx++;
      end
      case (k)
        99:   begin mode = 3'd3; solid = 24'h123456; end
        709:  mode = 3'd1;
        1059: mode = 3'd2;
        1409: mode = 3'd4;
        1759: mode = 3'd5;
        2109: begin mode = 3'd3; solid = 24'hABCDEF; end
        default: ;
      endcase
    end

    // Mid-line asynchronous reset while a solid active pixel is on the outputs
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.push_back(exp_word(24'h0, 0, 0, 1, 0, 0, 0));
    check("async_reset", act_word());
    exp_q.push_back(W'(2'b11));
    check("async_reset_pol0_sync", W'({hs0, vs0}));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(exp_word(24'hABCDEF, 0, 0, 0, 0, 0, 0));
    check("restart_0_0", act_word());
    @(posedge clk);
    #1;
    exp_q.push_back(exp_word(24'hABCDEF, 0, 0, 0, 1, 0, 0));
    check("restart_1_0", act_word());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Parametrised successor to the fixed 1280x720 test-picture VGA generator.
- Generates video timing (hsync, vsync, blank) and 8-bit RGB for any resolution and porch set.
- Offers selectable sync polarity, runtime-selectable test pattern latched per frame, frame counter and pixel coordinates.
- Sits in the clk_pixel domain, directly ahead of vga2dvid.

Parameters:
- C_resolution_x, 1280, active pixels per line (multiple of 8, >=8)
- C_hsync_front_porch, 82, pixels
- C_hsync_pulse, 80, pixels
- C_hsync_back_porch, 216, pixels
- C_resolution_y, 720, active lines
- C_vsync_front_porch, 3, lines
- C_vsync_pulse, 5, lines
- C_vsync_back_porch, 22, lines
- C_hsync_pol, 1, active level of hsync
- C_vsync_pol, 1, active level of vsync
- C_check_log2, 5, checkerboard square size = 2^N pixels
- C_cnt_bits, 12, width of x/y counters (must hold total-1)

Ports:
- clk_pixel  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  3  pattern select, sampled at frame start
- solid_rgb  in  24  {r,g,b} colour for mode 3
- vga_r / vga_g / vga_b  out  8 each  pixel colour
- vga_hsync  out  1  horizontal sync at C_hsync_pol
- vga_vsync  out  1  vertical sync at C_vsync_pol
- vga_blank  out  1  1 outside active area
- pos_x / pos_y  out  C_cnt_bits each  coordinates of the pixel currently on the outputs
- frame_cnt  out  16  completed-frame count

Behaviour:
- Htotal = res_x + fp + pulse + bp; vtotal is defined the same way. hcnt runs 0..htotal-1. vcnt advances when hcnt wraps and runs 0..vtotal-1.
- Reset (async assert, synchronous release):
  - hcnt = vcnt = 0; frame_cnt = 0; latched mode = 0
  - rgb = 0; blank = 1; hsync = !C_hsync_pol; vsync = !C_vsync_pol; pos = 0
- Every edge with rst_n = 1:
  - All outputs register the decode of the current (hcnt, vcnt). Latency is exactly 1 cycle.
  - The counters then advance.
  - The first edge after release outputs pixel (0,0) with blank = 0.
- Active region: hcnt < res_x and vcnt < res_y. Outside it, blank = 1 and rgb = 0 regardless of mode.
- hsync is active for hcnt in [res_x+fp, res_x+fp+pulse) on every line, including vertical blanking. vsync is active for vcnt in [res_y+vfp, res_y+vfp+vpulse) for whole lines.
- Mode latch: mode is captured on the edge where hcnt = 0 and vcnt = 0. A mid-frame change takes effect next frame.
- frame_cnt increments on the edge processing (htotal-1, vtotal-1). It wraps 0xFFFF->0.
- Patterns (active pixels, x = hcnt, y = vcnt):
  - 0: 8 colour bars, bar = x / (res_x/8). Order: white, yellow, cyan, green, magenta, red, blue, black (full-scale 0xFF/0x00).
  - 1: checkerboard; white if x[N] ^ y[N] else black, N = C_check_log2.
  - 2: gradient; r = x[7:0], g = y[7:0], b = frame_cnt[7:0].
  - 3: solid; rgb = solid_rgb.
  - 4: moving bar; white where (x - frame_cnt[C_cnt_bits-1:0]) mod 2^C_cnt_bits < 16, else black.
  - 5-7: black, with blank/sync unaffected.

Optional Feature:
- Macro VIDEO_PATTERN_BORDER_EN.
- Defined: a 1-pixel white border (x = 0, x = res_x-1, y = 0, y = res_y-1) overrides the pattern in all modes, including 5-7.
- Undefined: no override; patterns as above.

Test Plan:
- Small config (res 16x8, h 2/3/4, v 1/2/3, htotal 25, vtotal 14, pol 1), release reset:
  - first output (0,0), blank = 0
  - hsync high exactly for hcnt 18..20
  - vsync high for lines 9..10
  - period 350 cycles
- Pol 0: reset drives hsync = vsync = 1; pulses go low for the same windows.
- Mode 0, res_x 16: pixels 0..1 rgb FFFFFF, 2..3 FFFF00, 14..15 000000. Blanking pixels are 0.
- Mode changed 0->3 mid-frame with solid_rgb 123456:
  - remainder of frame stays bars
  - next frame all active pixels 123456
  - frame_cnt 0->1 on frame boundary
- Assert rst_n low mid-line: outputs go to reset values immediately (asynchronously). After release, timing restarts at (0,0).
- Force frame_cnt to 0xFFFF via 65536 frames of the small config: wraps to 0. With the border macro, mode 5 shows white only on edge pixels.
